// File: rtl/uart_pkg.sv
// Shared definitions for the uart peripheral: register map, STATUS bit
// positions, FSM state encodings and the divisor floor.
package uart_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_DIVLO  = 3'd2;
    localparam logic [2:0] ADDR_DIVHI  = 3'd3;

    localparam int ST_RX_AVAIL   = 0;
    localparam int ST_TX_READY   = 1;
    localparam int ST_TX_BUSY    = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;

    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    // Divisors below MIN_DIV would leave no room for the mid-bit RX sample.
    function automatic logic [15:0] effectiveDiv(input logic [15:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/uart_if.sv
// CPU-side register bus of the uart (UARTaddr/UARTwrite/UARTwe/UARTread).
interface uart_if;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic       re;
    logic [7:0] rdata;

    modport master (output addr, wdata, we, re, input rdata);
    modport slave  (input addr, wdata, we, re, output rdata);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO holding received characters; head is
// visible combinationally, pop on empty and push on full are ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] head_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, rdPtr_q;
    logic [AW:0]   count_q;
    logic          doPush, doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign doPop   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign doPush  = push_i && (!full_o || doPop);
    assign head_o  = mem_q[rdPtr_q];

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doPush && !doPop) begin
                count_q <= count_q + 1'b1;
            end else if (doPop && !doPush) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart.sv
// Byte-wide 8N1 UART: one-byte THR feeding a TX shifter, oversampling-free
// mid-bit RX into a small FIFO, programmable baud divisor.
module uart
    import uart_pkg::*;
#(
    parameter logic [15:0] DIV_DEFAULT = 16'd434,
    parameter int          RX_DEPTH    = 4
) (
    input  logic   clk_i,
    input  logic   reset_i,
    uart_if.slave  bus,
    input  logic   rx_i,
    output logic   tx_o
);
    logic [15:0] div_q;
    logic [15:0] effDiv, halfDiv;

    logic        wrData, wrStatus, popReq;

    txState_t    txState_q;
    logic [15:0] txCnt_q;
    logic [2:0]  txBit_q;
    logic [7:0]  txShift_q, thr_q;
    logic        thrFull_q, tx_q;

    logic        rxSync1_q, rxSync2_q;
    rxState_t    rxState_q;
    logic [15:0] rxCnt_q;
    logic [2:0]  rxBit_q;
    logic [7:0]  rxShift_q;
    logic        rxPush_q, rxFrameErr_q;

    logic        overrun_q, overrun_d, frameErr_q, frameErr_d;
    logic [7:0]  fifoHead;
    logic        fifoEmpty, fifoFull;

    assign effDiv   = effectiveDiv(div_q);
    assign halfDiv  = effDiv >> 1;
    assign wrData   = bus.we && (bus.addr == ADDR_DATA);
    assign wrStatus = bus.we && (bus.addr == ADDR_STATUS);
    assign popReq   = bus.re && (bus.addr == ADDR_DATA);
    assign tx_o     = tx_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q <= DIV_DEFAULT;
        end else if (bus.we && bus.addr == ADDR_DIVLO) begin
            div_q[7:0] <= bus.wdata;
        end else if (bus.we && bus.addr == ADDR_DIVHI) begin
            div_q[15:8] <= bus.wdata;
        end
    end

    // tx_q reflects the state held during the previous cycle, hence tx falls one cycle after START is entered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            txState_q <= TX_IDLE;
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txShift_q <= '0;
            thr_q     <= '0;
            thrFull_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            case (txState_q)
                TX_START: tx_q <= 1'b0;
                TX_DATA:  tx_q <= txShift_q[0];
                default:  tx_q <= 1'b1;
            endcase
            if (wrData && !thrFull_q) begin
                thr_q     <= bus.wdata;
                thrFull_q <= 1'b1;
            end
            case (txState_q)
                TX_IDLE: begin
                    if (thrFull_q) begin
                        txShift_q <= thr_q;
                        thrFull_q <= 1'b0;
                        txCnt_q   <= effDiv - 16'd1;
                        txState_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (txCnt_q == '0) begin
                        txCnt_q   <= effDiv - 16'd1;
                        txBit_q   <= '0;
                        txState_q <= TX_DATA;
                    end else begin
                        txCnt_q <= txCnt_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (txCnt_q == '0) begin
                        txCnt_q   <= effDiv - 16'd1;
                        txShift_q <= txShift_q >> 1;
                        if (txBit_q == 3'd7) begin
                            txState_q <= TX_STOP;
                        end else begin
                            txBit_q <= txBit_q + 3'd1;
                        end
                    end else begin
                        txCnt_q <= txCnt_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (txCnt_q == '0) begin
                        if (thrFull_q) begin
                            txShift_q <= thr_q;
                            thrFull_q <= 1'b0;
                            txCnt_q   <= effDiv - 16'd1;
                            txState_q <= TX_START;
                        end else begin
                            txState_q <= TX_IDLE;
                        end
                    end else begin
                        txCnt_q <= txCnt_q - 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rxSync1_q    <= 1'b1;
            rxSync2_q    <= 1'b1;
            rxState_q    <= RX_IDLE;
            rxCnt_q      <= '0;
            rxBit_q      <= '0;
            rxShift_q    <= '0;
            rxPush_q     <= 1'b0;
            rxFrameErr_q <= 1'b0;
        end else begin
            rxSync1_q    <= rx_i;
            rxSync2_q    <= rxSync1_q;
            rxPush_q     <= 1'b0;
            rxFrameErr_q <= 1'b0;
            case (rxState_q)
                RX_IDLE: begin
                    if (!rxSync2_q) begin
                        rxCnt_q   <= halfDiv - 16'd1;
                        rxState_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rxCnt_q == '0) begin
                        if (rxSync2_q) begin
                            rxState_q <= RX_IDLE;
                        end else begin
                            rxCnt_q   <= effDiv - 16'd1;
                            rxBit_q   <= '0;
                            rxState_q <= RX_DATA;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_q - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rxCnt_q == '0) begin
                        rxShift_q <= {rxSync2_q, rxShift_q[7:1]};
                        rxCnt_q   <= effDiv - 16'd1;
                        if (rxBit_q == 3'd7) begin
                            rxState_q <= RX_STOP;
                        end else begin
                            rxBit_q <= rxBit_q + 3'd1;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_q - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rxCnt_q == '0) begin
                        rxPush_q     <= rxSync2_q;
                        rxFrameErr_q <= !rxSync2_q;
                        rxState_q    <= RX_IDLE;
                    end else begin
                        rxCnt_q <= rxCnt_q - 16'd1;
                    end
                end
            endcase
        end
    end

    uart_rx_fifo #(.DEPTH(RX_DEPTH)) rxFifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (rxPush_q),
        .pop_i   (popReq),
        .data_i  (rxShift_q),
        .head_o  (fifoHead),
        .empty_o (fifoEmpty),
        .full_o  (fifoFull)
    );

    // Sticky flags: a STATUS write clears them, but a same-cycle new event wins.
    always_comb begin
        overrun_d  = overrun_q;
        frameErr_d = frameErr_q;
        if (wrStatus) begin
            overrun_d  = 1'b0;
            frameErr_d = 1'b0;
        end
        if (rxPush_q && fifoFull && !popReq) begin
            overrun_d = 1'b1;
        end
        if (rxFrameErr_q) begin
            frameErr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overrun_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            overrun_q  <= overrun_d;
            frameErr_q <= frameErr_d;
        end
    end

    always_comb begin
        bus.rdata = 8'h00;
        case (bus.addr)
            ADDR_DATA:   bus.rdata = fifoEmpty ? 8'h00 : fifoHead;
            ADDR_STATUS: begin
                bus.rdata[ST_RX_AVAIL]   = !fifoEmpty;
                bus.rdata[ST_TX_READY]   = !thrFull_q;
                bus.rdata[ST_TX_BUSY]    = (txState_q != TX_IDLE);
                bus.rdata[ST_RX_OVERRUN] = overrun_q;
                bus.rdata[ST_FRAME_ERR]  = frameErr_q;
            end
            ADDR_DIVLO:  bus.rdata = div_q[7:0];
            ADDR_DIVHI:  bus.rdata = div_q[15:8];
            default:     bus.rdata = 8'h00;
        endcase
    end

endmodule
